// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store sequencer with read-modify-write sub-word stores
// Optional write trace: define LSU_TRACE_EN.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       pc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t state, state_n;

  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              err_q;

  logic        accept_bad;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] wr_word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [ADDR_W-1:0] word_addr;

  assign accept_bad = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

  assign lane_sh   = {addr_q[1:0], 3'b000};
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign err       = err_q;

  // Store merge: replace the addressed lane of the captured word.
  always_comb begin
    lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << lane_sh) : (32'h0000_FFFF << lane_sh);
    merged    = (word_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    wr_word   = (size_q == 2'b10) ? wdata_q : merged;
  end

  // Load extraction straight from the memory read port during RD.
  always_comb begin
    shifted = mem_dout >> lane_sh;
    case (size_q)
      2'b00:   load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (accept_bad)                 state_n = DONE;
          else if (we && size == 2'b10)   state_n = WR;
          else                            state_n = RD;
        end
      end
      RD: begin
        mem_addr = word_addr;
        state_n  = we_q ? WR : DONE;
      end
      WR: begin
        mem_addr = word_addr;
        mem_din  = wr_word;
        // A reset landing on WR must not let the write reach memory.
        mem_we   = !reset;
        state_n  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef LSU_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset)                   pc_q <= '0;
    else if (state == IDLE && req) pc_q <= pc;
  end

  always_ff @(posedge clk) begin
    if (!reset && state == WR) $display("@%h: *%h <= %h", pc_q, mem_addr, mem_din);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        sign_q  <= sign;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= accept_bad;
      end
      if (state == RD) begin
        word_q <= mem_dout;
        if (!we_q) rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a byte-array reference
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req, we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .pc(pc), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  // Data memory attached to the DUT: 64 words, combinational read.
  logic [31:0] mem [0:63];
  assign mem_dout = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_din;

  // Reference memory as individual bytes.
  logic [7:0]  ref_b [0:255];
  logic [31:0] exp_rdata;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  task automatic preset(input int a, input logic [31:0] w);
    mem[(a >> 2) & 63] = w;
    for (int i = 0; i < 4; i++) ref_b[(a & ~3) + i] = w[8*i +: 8];
  endtask

  // Issue one request at a negedge; returns at the negedge after the DUT is idle again.
  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input int a, input logic [31:0] wd, input logic [31:0] p);
    bit bad;
    int n, exp_lat, lat, nwr;
    logic [31:0] ev, wa, wdin;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_lat = bad ? 1 : (w && sz != 2'b10) ? 3 : 2;
    if (!bad && !w) begin
      ev = '0;
      for (int i = 0; i < n; i++) ev[8*i +: 8] = ref_b[a + i];
      if (sg && n < 4 && ev[8*n-1])
        for (int i = n; i < 4; i++) ev[8*i +: 8] = 8'hFF;
      exp_rdata = ev;
    end
    if (!bad && w)
      for (int i = 0; i < n; i++) ref_b[a + i] = wd[8*i +: 8];

    we = w; size = sz; sign = sg; addr = a; wdata = wd; pc = p; req = 1'b1;
    lat = -1; nwr = 0; wa = '0; wdin = '0;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      @(negedge clk);
      // Everything presented while busy must be ignored.
      req = 1'(($urandom_range(0, 1)));
      we = 1'($urandom); size = 2'($urandom); sign = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      if (k == 0) check("busy_after_accept", {31'b0, busy}, 32'd1);
      if (mem_we) begin nwr++; wa = mem_addr; wdin = mem_din; end
      if (done) begin
        lat = k + 1;
        check("err", {31'b0, err}, {31'b0, bad});
        check("rdata", rdata, exp_rdata);
      end
    end
    check("latency", lat, exp_lat);
    check("write_count", nwr, (!bad && w) ? 1 : 0);
    if (!bad && w) begin
      check("write_addr", wa, a & ~3);
      check("write_data", wdin, ref_word(a));
    end
    @(negedge clk);
    req = 1'b0;
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_done", {31'b0, done}, 32'd0);
    check("mem_word", mem[(a >> 2) & 63], ref_word(a));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) preset(i * 4, $urandom);
    exp_rdata = '0;

    // Reset with a request pending: it must be ignored.
    preset(32'h10, 32'hCAFE_F00D);
    reset = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; sign = 1'b0;
    addr = 32'h10; wdata = 32'h1111_2222; pc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0; req = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check("rst_no_accept", {31'b0, busy}, 32'd0);
    check("rst_no_write", mem[4], 32'hCAFE_F00D);

    // Word store then load.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h100);
    access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h104);
    check("lw_value", rdata, 32'h1234_5678);

    // Byte store read-modify-write.
    preset(32'h20, 32'hAABB_CCDD);
    access(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_0011, 32'h108);
    check("sb_merge", mem[8], 32'hAA11_CCDD);

    // Sub-word loads.
    preset(32'h30, 32'h8000_F0FF);
    access(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 32'h10C);
    check("lb", rdata, 32'hFFFF_FFFF);
    access(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'h110);
    check("lbu", rdata, 32'h0000_00F0);
    access(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h114);
    check("lh", rdata, 32'hFFFF_8000);
    access(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'h118);
    check("lhu", rdata, 32'h0000_8000);

    // Errors leave memory and rdata alone.
    access(1'b0, 2'b10, 1'b0, 32'h31, 32'h0, 32'h11C);
    access(1'b1, 2'b01, 1'b0, 32'h33, 32'hDEAD_BEEF, 32'h120);
    access(1'b1, 2'b11, 1'b0, 32'h34, 32'hDEAD_BEEF, 32'h124);
    check("err_rdata_kept", rdata, 32'h0000_8000);

    // Reset while in WR of a byte store.
    preset(32'h40, 32'h0102_0304);
    we = 1'b1; size = 2'b00; sign = 1'b0; addr = 32'h41; wdata = 32'h99; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("rmw_rd_no_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check("rmw_in_wr", {31'b0, mem_we}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = '0;
    check("wr_reset_busy", {31'b0, busy}, 32'd0);
    check("wr_reset_done", {31'b0, done}, 32'd0);
    check("wr_reset_mem", mem[16], 32'h0102_0304);
    check("wr_reset_rdata", rdata, 32'd0);

    // Trace sample store.
    access(1'b1, 2'b10, 1'b0, 32'h8, 32'h5, 32'h3004);

    // Random mix against the byte model.
    for (int t = 0; t < 150; t++)
      access(1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 252)), $urandom, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
